// File: rtl/smem_pkg.sv
// Shared widths, defaults and FSM encoding for the shared-memory bank arbiter.
// Optional read broadcast is enabled by defining SMEM_BROADCAST_EN.
package smem_pkg;

    localparam int SMEM_LANES = 4;
    localparam int SMEM_BANKS = 16;
    localparam int ROW_W      = 8;
    localparam int BANK_W     = 4;
    localparam int ADDR_W     = BANK_W + ROW_W;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } smem_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/smem_conflict_resolver.sv
// Per-bank grant of the lowest-index pending lane; with SMEM_BROADCAST_EN defined,
// read lanes hitting the same bank and row as a granted lane are served in the same round.
module smem_conflict_resolver
    import smem_pkg::*;
#(
    parameter int LANES = SMEM_LANES,
    parameter int BANKS = SMEM_BANKS,
    parameter int LANE_W = idx_w(LANES)
) (
    input  logic [LANES-1:0]        pending_i,
    input  logic                    write_i,
    input  logic [ADDR_W*LANES-1:0] addr_i,
    output logic [BANKS-1:0]        bank_grant_o,
    output logic [BANKS*LANE_W-1:0] bank_lane_o,
    output logic [LANES-1:0]        lane_served_o
);

    logic [BANK_W-1:0] lane_bank [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_fields
        assign lane_bank[g] = addr_i[g*ADDR_W+ROW_W +: BANK_W];
    end

`ifdef SMEM_BROADCAST_EN
    logic [ROW_W-1:0] lane_row [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_rows
        assign lane_row[g] = addr_i[g*ADDR_W +: ROW_W];
    end
`else
    logic unused_write;
    assign unused_write = write_i;
`endif

    always_comb begin
        bank_grant_o  = '0;
        bank_lane_o   = '0;
        lane_served_o = '0;
        // Descending scan so the lowest pending lane is the last (winning) write.
        for (int b = 0; b < BANKS; b++) begin
            for (int i = LANES - 1; i >= 0; i--) begin
                if (pending_i[i] && (lane_bank[i] == BANK_W'(b))) begin
                    bank_grant_o[b]                 = 1'b1;
                    bank_lane_o[b*LANE_W +: LANE_W] = LANE_W'(i);
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_grant_o[b] && (lane_bank[i] == BANK_W'(b))) begin
                    if (bank_lane_o[b*LANE_W +: LANE_W] == LANE_W'(i)) begin
                        lane_served_o[i] = 1'b1;
                    end
`ifdef SMEM_BROADCAST_EN
                    else if (!write_i && pending_i[i] &&
                             (lane_row[i] == lane_row[bank_lane_o[b*LANE_W +: LANE_W]])) begin
                        lane_served_o[i] = 1'b1;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: rtl/smem_bank_arbiter.sv
// Batches per-lane requests onto 16 single-port banks, serializing bank conflicts in rounds.
// Read broadcast within a round is enabled by defining SMEM_BROADCAST_EN.
module smem_bank_arbiter
    import smem_pkg::*;
#(
    parameter int LANES = SMEM_LANES,
    parameter int BANKS = SMEM_BANKS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [LANES-1:0]        req_mask,
    input  logic [ADDR_W*LANES-1:0] req_addr,
    input  logic [DATA_W*LANES-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [DATA_W*LANES-1:0] resp_rdata,
    output logic [BANKS-1:0]        bank_read,
    output logic [BANKS-1:0]        bank_write,
    output logic [ROW_W*BANKS-1:0]  bank_addr,
    output logic [DATA_W*BANKS-1:0] bank_wdata,
    input  logic [DATA_W*BANKS-1:0] bank_rdata,
    input  logic [BANKS-1:0]        bank_finish,
    output smem_state_e             dbg_state_o
);

    localparam int LANE_W = idx_w(LANES);

    // Handshake: a batch is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so req_valid is ignored while a batch is in flight.

    smem_state_e             state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    write_q, write_d;
    logic [ADDR_W*LANES-1:0] addr_q, addr_d;
    logic [DATA_W*LANES-1:0] wdata_q, wdata_d;
    logic [LANES-1:0]        pending_q, pending_d;
    logic [LANES-1:0]        served_q, served_d;
    logic [BANKS-1:0]        grant_q, grant_d;
    logic [DATA_W*LANES-1:0] rdata_q, rdata_d;

    logic [BANKS-1:0]        res_grant;
    logic [BANKS*LANE_W-1:0] res_lane;
    logic [LANES-1:0]        res_served;
    logic [LANE_W-1:0]       sel_lane [BANKS];
    logic [BANK_W-1:0]       lane_bank [LANES];

    smem_conflict_resolver #(
        .LANES  (LANES),
        .BANKS  (BANKS),
        .LANE_W (LANE_W)
    ) u_resolver (
        .pending_i     (pending_q),
        .write_i       (write_q),
        .addr_i        (addr_q),
        .bank_grant_o  (res_grant),
        .bank_lane_o   (res_lane),
        .lane_served_o (res_served)
    );

    for (genvar g = 0; g < BANKS; g++) begin : g_sel
        assign sel_lane[g] = res_lane[g*LANE_W +: LANE_W];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane_bank
        assign lane_bank[g] = addr_q[g*ADDR_W+ROW_W +: BANK_W];
    end

    // Bank strobes are live only during the ISSUE cycle of each round.
    always_comb begin
        bank_read  = '0;
        bank_write = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        if (state_q == ISSUE) begin
            for (int b = 0; b < BANKS; b++) begin
                if (res_grant[b]) begin
                    bank_read[b]                 = !write_q;
                    bank_write[b]                = write_q;
                    bank_addr[b*ROW_W +: ROW_W]   = addr_q[int'(sel_lane[b])*ADDR_W +: ROW_W];
                    bank_wdata[b*DATA_W +: DATA_W] = wdata_q[int'(sel_lane[b])*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pending_d  = pending_q;
        served_d   = served_q;
        grant_d    = grant_q;
        rdata_d    = rdata_q;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    write_d   = req_write;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    pending_d = req_mask;
                    rdata_d   = '0;
                    state_d   = (req_mask == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                served_d = res_served;
                grant_d  = res_grant;
                state_d  = WAIT;
            end
            WAIT: begin
                if ((grant_q & ~bank_finish) == '0) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (served_q[i] && !write_q) begin
                            rdata_d[i*DATA_W +: DATA_W] =
                                bank_rdata[int'(lane_bank[i])*DATA_W +: DATA_W];
                        end
                    end
                    pending_d = pending_q & ~served_q;
                    state_d   = (pending_d != '0) ? ISSUE : DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            served_q  <= '0;
            grant_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            grant_q   <= grant_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready   = ready_q;
    assign resp_rdata  = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_smem_bank_arbiter.sv
// Randomized bench for smem_bank_arbiter against a batch-level memory/latency model.
// Define SMEM_BROADCAST_EN for both bench and RTL to check the broadcast build.
module tb_smem_bank_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_write;
    logic [3:0]   req_mask;
    logic [47:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic [15:0]  bank_read, bank_write;
    logic [127:0] bank_addr, bank_wdata;
    logic [127:0] bank_rdata = '0;
    logic [15:0]  bank_finish = '0;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem     [16][256];
    logic [7:0] ref_mem [16][256];

    logic [31:0] got_rdata;
    int          got_lat;
    int          got_strobes;

    always #5 clock = ~clock;

    smem_bank_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_mask    (req_mask),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .bank_read   (bank_read),
        .bank_write  (bank_write),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .bank_finish (bank_finish),
        .dbg_state_o (dbg_state)
    );

    // Banks: registered read data and a one-cycle finish after each strobe.
    always @(posedge clock) begin
        for (int b = 0; b < 16; b++) begin
            bank_finish[b] <= bank_read[b] | bank_write[b];
            if (bank_write[b]) mem[b][bank_addr[b*8 +: 8]] = bank_wdata[b*8 +: 8];
            if (bank_read[b]) bank_rdata[b*8 +: 8] <= mem[b][bank_addr[b*8 +: 8]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Rounds a bank needs: one per lane, or one per distinct row for broadcast reads.
    function automatic int bank_rounds(input logic wr, input logic [3:0] mask,
                                       input logic [47:0] addr, input int b);
        int n = 0;
        logic dup;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && int'(addr[12*i+8 +: 4]) == b) begin
                dup = 1'b0;
`ifdef SMEM_BROADCAST_EN
                for (int j = 0; j < i; j++) begin
                    if (!wr && mask[j] && addr[12*j +: 12] == addr[12*i +: 12]) dup = 1'b1;
                end
`endif
                if (!dup) n++;
            end
        end
        return n;
    endfunction

    task automatic do_batch(input string tag, input logic wr, input logic [3:0] mask,
                            input logic [47:0] addr, input logic [31:0] wd);
        logic [31:0] exp_rd;
        int rounds, strobes, exp_lat, r, wait_n, bk, rw;
        bit done;
        exp_rd  = '0;
        rounds  = 0;
        strobes = 0;
        for (int b = 0; b < 16; b++) begin
            r = bank_rounds(wr, mask, addr, b);
            strobes += r;
            if (r > rounds) rounds = r;
        end
        exp_lat = (mask == 4'd0) ? 1 : 1 + 2 * rounds;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                bk = int'(addr[12*i+8 +: 4]);
                rw = int'(addr[12*i +: 8]);
                if (wr) ref_mem[bk][rw] = wd[8*i +: 8];
                else exp_rd[8*i +: 8] = ref_mem[bk][rw];
            end
        end
        @(negedge clock);
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clock);
            wait_n++;
        end
        check_eq({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_mask  = mask;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_mask  = 4'($urandom);
        req_addr  = 48'({$urandom, $urandom});
        req_wdata = $urandom;
        got_lat     = 0;
        got_strobes = 0;
        done        = 1'b0;
        while (!done && got_lat < 100) begin
            @(negedge clock);
            got_lat++;
            got_strobes += $countones(bank_read | bank_write);
            if (resp_valid) done = 1'b1;
        end
        req_valid = 1'b0;
        got_rdata = resp_rdata;
        check_eq({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
        check_eq({tag, "_strobes"}, 64'(got_strobes), 64'(strobes));
        check_eq({tag, "_rdata"}, got_rdata, exp_rd);
        repeat (2) @(negedge clock);
        check_eq({tag, "_hold"}, {resp_valid, resp_rdata}, {1'b0, exp_rd});
    endtask

    task automatic reset_mid_batch();
        bit seen;
        int wait_n;
        @(negedge clock);
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clock);
            wait_n++;
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_mask  = 4'hF;
        req_addr  = {4'h5, 8'h03, 4'h5, 8'h02, 4'h5, 8'h01, 4'h5, 8'h00};
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        check_eq("rst_strobes", {bank_read, bank_write}, 0);
        check_eq("rst_bank_bus", (bank_addr | bank_wdata), 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_ready_rise", req_ready, 1);
        repeat (10) begin
            if (resp_valid) seen = 1'b1;
            @(negedge clock);
        end
        check_eq("rst_no_resp", seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] a;
        for (int b = 0; b < 16; b++) begin
            for (int r = 0; r < 256; r++) begin
                mem[b][r]     = 8'($urandom);
                ref_mem[b][r] = mem[b][r];
            end
        end
        mem[7][8'h20]     = 8'hA5;
        ref_mem[7][8'h20] = 8'hA5;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_mask  = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clock);
        check_eq("init_ready", req_ready, 0);
        check_eq("init_valid", resp_valid, 0);
        check_eq("init_rdata", resp_rdata, 0);
        check_eq("init_strobes", {bank_read, bank_write}, 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("init_ready_rise", req_ready, 1);

        do_batch("wr_spread", 1'b1, 4'hF, {4'h3, 8'h10, 4'h2, 8'h10, 4'h1, 8'h10, 4'h0, 8'h10},
                 32'h44332211);
        check_eq("wr_spread_lat3", 64'(got_lat), 3);
        do_batch("rd_spread", 1'b0, 4'hF, {4'h3, 8'h10, 4'h2, 8'h10, 4'h1, 8'h10, 4'h0, 8'h10}, '0);
        check_eq("rd_spread_data", got_rdata, 32'h44332211);

        do_batch("rd_bank5", 1'b0, 4'hF, {4'h5, 8'h03, 4'h5, 8'h02, 4'h5, 8'h01, 4'h5, 8'h00}, '0);
        check_eq("rd_bank5_lat9", 64'(got_lat), 9);

        do_batch("rd_same", 1'b0, 4'hF, {4'h7, 8'h20, 4'h7, 8'h20, 4'h7, 8'h20, 4'h7, 8'h20}, '0);
        check_eq("rd_same_data", got_rdata, 32'hA5A5A5A5);
`ifdef SMEM_BROADCAST_EN
        check_eq("rd_same_lat", 64'(got_lat), 3);
`else
        check_eq("rd_same_lat", 64'(got_lat), 9);
`endif

        do_batch("wr_order", 1'b1, 4'hF, {4'h2, 8'h00, 4'h2, 8'h00, 4'h2, 8'h00, 4'h2, 8'h00},
                 32'h04030201);
        do_batch("rd_order", 1'b0, 4'h1, {36'h0, 4'h2, 8'h00}, '0);
        check_eq("rd_order_data", got_rdata, 32'h00000004);

        do_batch("mask0", 1'b0, 4'h0, {4'h2, 8'h00, 4'h2, 8'h00, 4'h2, 8'h00, 4'h2, 8'h00}, '0);
        check_eq("mask0_lat1", 64'(got_lat), 1);
        check_eq("mask0_rdata0", got_rdata, 0);

        reset_mid_batch();
        do_batch("post_rst", 1'b0, 4'hF, {4'h5, 8'h03, 4'h5, 8'h02, 4'h5, 8'h01, 4'h5, 8'h00}, '0);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n < 30) a[12*i +: 12] = {4'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
                else a[12*i +: 12] = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            end
            do_batch("rand", 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
